// File: rtl/psa_arbiter.sv
// Two-requester round-robin front end for one shared PSA_16bit nibble adder.
// Each accepted request passes through IDLE -> EXEC -> RESP. The response is
// held in RESP until it is acknowledged.

// PSA_16bit: four independent 4-bit signed adds. Error is set when any nibble
// overflows as a signed value.
module psa_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o,
    output logic        error_o
);

    // Per-nibble wrapped sum and signed-overflow detection.
    always_comb begin
        sum_o   = '0;
        error_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum_o[4*i +: 4] = a_i[4*i +: 4] + b_i[4*i +: 4];
            if ((a_i[4*i+3] == b_i[4*i+3]) && (sum_o[4*i+3] != a_i[4*i+3])) begin
                error_o = 1'b1;
            end
        end
    end

endmodule

module psa_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [15:0]      a0,
    input  logic [15:0]      b0,
    input  logic             req1,
    input  logic [15:0]      a1,
    input  logic [15:0]      b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [15:0]      rsp_sum,
    output logic             rsp_err,
    input  logic             rsp_ack,
    output logic             busy,
    output logic [CNT_W-1:0] ovfl_cnt
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;          // 1: requester 1 wins a tie
    logic [15:0]        op_a_q, op_a_d;
    logic [15:0]        op_b_q, op_b_d;
    logic               id_q, id_d;
    logic               rsp_id_q, rsp_id_d;
    logic [15:0]        rsp_sum_q, rsp_sum_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        psa_sum;
    logic               psa_err;

    psa_16bit u_psa (
        .a_i     (op_a_q),
        .b_i     (op_b_q),
        .sum_o   (psa_sum),
        .error_o (psa_err)
    );

    // Next-state, grant and capture logic.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        rsp_sum_d = rsp_sum_q;
        rsp_err_d = rsp_err_q;
        cnt_d     = cnt_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Grants are combinational, so mask them while reset is held.
                if (rst_n) begin
                    if (req0 && (!req1 || !rr_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0) begin
                    op_a_d  = a0;
                    op_b_d  = b0;
                    id_d    = 1'b0;
                    rr_d    = 1'b1;
                    state_d = StExec;
                end else if (gnt1) begin
                    op_a_d  = a1;
                    op_b_d  = b1;
                    id_d    = 1'b1;
                    rr_d    = 1'b0;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_sum_d = psa_sum;
                rsp_err_d = psa_err;
                rsp_id_d  = id_q;
                if (psa_err && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            id_q      <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_sum_q <= '0;
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            id_q      <= id_d;
            rsp_id_q  <= rsp_id_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_err_q <= rsp_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;
    assign ovfl_cnt  = cnt_q;

endmodule

// File: tb/tb_psa_arbiter.sv
// Directed bench for psa_arbiter; outputs sampled 1 ns after the falling edge.
module tb_psa_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0;
    logic [15:0] a0 = '0;
    logic [15:0] b0 = '0;
    logic        req1 = 1'b0;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        gnt0;
    logic        gnt1;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_err;
    logic        rsp_ack = 1'b0;
    logic        busy;
    logic [7:0]  ovfl_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psa_arbiter #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .rsp_ack   (rsp_ack),
        .busy      (busy),
        .ovfl_cnt  (ovfl_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks every output against its reset value.
    task automatic check_idle_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_gnts"}, 32'({gnt1, gnt0}), 32'h0);
        check({tag, "_id"}, 32'(rsp_id), 32'h0);
        check({tag, "_sum"}, 32'(rsp_sum), 32'h0);
        check({tag, "_err"}, 32'(rsp_err), 32'h0);
        check({tag, "_ovfl"}, 32'(ovfl_cnt), 32'h0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        rsp_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called in an IDLE cycle with requests already driven; acks in the first RESP cycle.
    task automatic run_op(input logic exp_id, input logic [15:0] exp_sum, input logic exp_err,
                          input string tag);
        #1;
        check({tag, "_gnts"}, 32'({gnt1, gnt0}), exp_id ? 32'h2 : 32'h1);
        @(negedge clk); #1;
        check({tag, "_exec_busy"}, 32'(busy), 32'h1);
        check({tag, "_exec_gnts"}, 32'({gnt1, gnt0}), 32'h0);
        check({tag, "_exec_valid"}, 32'(rsp_valid), 32'h0);
        @(negedge clk); #1;
        check({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ack = 1'b1;
        @(negedge clk); #1;
        check({tag, "_valid_clr"}, 32'(rsp_valid), 32'h0);
        rsp_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_idle_reset("rst");
        do_reset();

        // Spurious ack in IDLE is ignored.
        rsp_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_idle_reset("spur");
        end
        rsp_ack = 1'b0;

        // Single request from requester 0.
        @(negedge clk);
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
        run_op(1'b0, 16'h2345, 1'b0, "single");
        req0 = 1'b0;
        check("single_ovfl", 32'(ovfl_cnt), 32'h0);

        // Contention from a fresh pointer: order 0,1,0,1.
        do_reset();
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
        req1 = 1'b1; a1 = 16'h0101; b1 = 16'h0202;
        run_op(1'b0, 16'h2345, 1'b0, "rr0");
        run_op(1'b1, 16'h0303, 1'b0, "rr1");
        run_op(1'b0, 16'h2345, 1'b0, "rr2");
        run_op(1'b1, 16'h0303, 1'b0, "rr3");
        req0 = 1'b0; req1 = 1'b0;

        // Overflow counting and saturation: 259 error ops in total.
        do_reset();
        req1 = 1'b1; a1 = 16'h0007; b1 = 16'h0001;
        run_op(1'b1, 16'h0008, 1'b1, "ov");
        check("ov_cnt1", 32'(ovfl_cnt), 32'h1);
        rsp_ack = 1'b1;
        repeat (3 * 253) @(negedge clk);
        #1 check("ov_cnt254", 32'(ovfl_cnt), 32'd254);
        repeat (3) @(negedge clk);
        #1 check("ov_cnt255", 32'(ovfl_cnt), 32'd255);
        repeat (3 * 4) @(negedge clk);
        #1 check("ov_sat", 32'(ovfl_cnt), 32'd255);
        req1 = 1'b0; rsp_ack = 1'b0;

        // Backpressure with requester 1 pending.
        do_reset();
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
        #1 check("bp_gnt0", 32'({gnt1, gnt0}), 32'h1);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 16'h0007; b1 = 16'h0001;
        #1 check("bp_exec_gnts", 32'({gnt1, gnt0}), 32'h0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_sum", 32'(rsp_sum), 32'h2345);
            check("bp_id", 32'(rsp_id), 32'h0);
            check("bp_busy", 32'(busy), 32'h1);
            check("bp_gnts", 32'({gnt1, gnt0}), 32'h0);
            @(negedge clk);
        end
        rsp_ack = 1'b1;
        #1 check("bp_ack_gnts", 32'({gnt1, gnt0}), 32'h0);
        @(negedge clk); #1;
        rsp_ack = 1'b0;
        check("bp_idle_busy", 32'(busy), 32'h0);
        check("bp_idle_gnt1", 32'({gnt1, gnt0}), 32'h2);
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk); #1;
        check("bp_r1_valid", 32'(rsp_valid), 32'h1);
        check("bp_r1_id", 32'(rsp_id), 32'h1);
        check("bp_r1_sum", 32'(rsp_sum), 32'h0008);
        check("bp_r1_err", 32'(rsp_err), 32'h1);
        check("bp_r1_ovfl", 32'(ovfl_cnt), 32'h1);
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;

        // Reset during EXEC discards the operation.
        req0 = 1'b1; a0 = 16'h4321; b0 = 16'h1111;
        #1 check("rx_gnt0", 32'({gnt1, gnt0}), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_idle_reset("rx_rst");
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rx_post_valid", 32'(rsp_valid), 32'h0);
            check("rx_post_busy", 32'(busy), 32'h0);
        end
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111;
        run_op(1'b0, 16'h2345, 1'b0, "rx_first");
        req0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
